// File: rtl/piece_queue_if.sv
// piece_queue_if: random-input / piece-output bundle between the generator,
// the next-piece queue and the game FSM. DEPTH must match the queue instance.
interface piece_queue_if #(
    parameter int DEPTH = 4
);
    logic [3:0]             RAND;
    logic                   TAKE;
    logic [2:0]             PIECE;
    logic                   VALID;
    logic                   FULL;
    logic [3*(DEPTH-1)-1:0] PREVIEW;

    // Game side: supplies random values and pop strobes, reads the queue.
    modport master (
        output RAND,
        output TAKE,
        input  PIECE,
        input  VALID,
        input  FULL,
        input  PREVIEW
    );

    // Queue side.
    modport slave (
        input  RAND,
        input  TAKE,
        output PIECE,
        output VALID,
        output FULL,
        output PREVIEW
    );
endinterface

// File: rtl/piece_queue.sv
// piece_queue: next-piece FIFO for Tetris. Filters raw 4-bit random values
// into tetrimino codes 0..6, holds DEPTH entries (head + preview slots) and
// pops the head on a single-cycle TAKE. Empty slots always read 7.
// Optional feature: define PIECE_QUEUE_NO_REPEAT_EN to reject a candidate
// equal to the most recently pushed code.
module piece_queue #(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    piece_queue_if.slave bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [2:0]    NONE    = 3'd7;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FILLING,
        S_FULL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    slots_q [DEPTH];
    logic [2:0]    slots_d [DEPTH];
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] base;
    logic          accept;
    logic          pop;
    logic          push;

    // Decide whether this cycle pops, and whether the incoming value is pushed.
    always_comb begin
        accept = (bus.RAND <= 4'd6);
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        if (bus.RAND[2:0] == last_q) begin
            accept = 1'b0;
        end
`endif
        pop  = bus.TAKE && (count_q != '0);
        // A same-cycle pop frees a slot even when full.
        push = accept && ((count_q < DEPTH_C) || pop);
    end

    // Slot/count update: shift first, then place the new code at the tail.
    always_comb begin
        slots_d = slots_q;
        last_d  = last_q;
        base    = count_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slots_d[i] = slots_q[i + 1];
            end
            slots_d[DEPTH-1] = NONE;
            base             = count_q - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == base) begin
                    slots_d[i] = bus.RAND[2:0];
                end
            end
            last_d = bus.RAND[2:0];
        end
        count_d = base + {{(CW-1){1'b0}}, push};
        // Anything beyond the occupancy is forced empty so no stale code shows.
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) >= count_d) begin
                slots_d[i] = NONE;
            end
        end
    end

    // Storage, occupancy, last-pushed code and FSM state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_EMPTY;
            count_q <= '0;
            last_q  <= NONE;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= NONE;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            slots_q <= slots_d;
        end
    end

    // Next-state logic, tracking the occupancy class of the FIFO.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (push) begin
                    state_d = S_FILLING;
                end
            end
            S_FILLING: begin
                if (push && !pop && (count_q == DEPTH_C - 1'b1)) begin
                    state_d = S_FULL;
                end else if (pop && !push && (count_q == CW'(1))) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop && !push) begin
                    state_d = S_FILLING;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Outputs come straight from registers: no input-to-output path.
    always_comb begin
        bus.VALID   = (state_q != S_EMPTY);
        bus.FULL    = (state_q == S_FULL);
        bus.PIECE   = slots_q[0];
        bus.PREVIEW = '1;
        for (int k = 1; k < DEPTH; k++) begin
            bus.PREVIEW[3*k-3 +: 3] = slots_q[k];
        end
    end
endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: directed + randomised bench for piece_queue (DEPTH=4).
// A queue of expected pieces is grown as acceptable values are driven and
// popped (and compared against PIECE) when TAKE consumes the head.
module tb_piece_queue;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RESET;

    piece_queue_if #(.DEPTH(DEPTH)) bus ();

    piece_queue #(.DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int mq[$];
    int last_m;
    int ncmp  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the expected queue contents.
    task automatic check_all(input string tag);
        logic [2:0] ep;
        logic [3*(DEPTH-1)-1:0] epv;
        ep = (mq.size() > 0) ? 3'(mq[0]) : 3'd7;
        for (int k = 1; k < DEPTH; k++) begin
            epv[3*k-3 +: 3] = (k < mq.size()) ? 3'(mq[k]) : 3'd7;
        end
        chk({tag, "_piece"},   32'(bus.PIECE),   32'(ep));
        chk({tag, "_preview"}, 32'(bus.PREVIEW), 32'(epv));
        chk({tag, "_valid"},   32'(bus.VALID),   32'(mq.size() > 0));
        chk({tag, "_full"},    32'(bus.FULL),    32'(mq.size() == DEPTH));
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic step(input string tag, input logic [3:0] r, input logic t);
        int  sz;
        int  popped;
        bit  pop;
        bit  acc;
        bit  push;
        bus.RAND = r;
        bus.TAKE = t;
        sz  = mq.size();
        pop = t && (sz > 0);
        if (pop) begin
            popped = mq.pop_front();
            chk({tag, "_take_head"}, 32'(bus.PIECE), 32'(popped));
        end
        acc = (r <= 4'd6);
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        if (int'(r) == last_m) acc = 1'b0;
`endif
        push = acc && ((sz < DEPTH) || pop);
        if (push) begin
            mq.push_back(int'(r));
            last_m = int'(r);
        end
        @(posedge CLK);
        #1;
        check_all(tag);
        @(negedge CLK);
    endtask

    task automatic sync_reset_model();
        mq.delete();
        last_m = 7;
    endtask

    initial begin
        RESET    = 1'b1;
        bus.RAND = 4'd15;
        bus.TAKE = 1'b0;
        sync_reset_model();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_all("reset");
        RESET = 1'b0;

        // Fill from reset release: full after exactly DEPTH edges.
        step("fill0", 4'd3, 1'b0);
        step("fill1", 4'd5, 1'b0);
        step("fill2", 4'd1, 1'b0);
        step("fill3", 4'd6, 1'b0);
        chk("fill_piece",   32'(bus.PIECE),   32'(3'd3));
        chk("fill_preview", 32'(bus.PREVIEW), 32'({3'd6, 3'd1, 3'd5}));
        chk("fill_full",    32'(bus.FULL),    32'd1);

        // Pop with push while full stays full.
        step("poppush_full", 4'd2, 1'b1);
        chk("poppush_preview", 32'(bus.PREVIEW), 32'({3'd2, 3'd6, 3'd1}));
        chk("poppush_fullflag", 32'(bus.FULL), 32'd1);

        // Overfill attempts leave contents unchanged.
        step("overfill_a", 4'd2, 1'b0);
        step("overfill_b", 4'd0, 1'b0);

        // Async reset pulse between edges clears outputs before the next edge.
        #2;
        RESET = 1'b1;
        #1;
        sync_reset_model();
        check_all("async_rst");
        @(negedge CLK);
        RESET = 1'b0;

        // Rejection of out-of-range values.
        step("rej7",  4'd7,  1'b0);
        step("rej15", 4'd15, 1'b0);
        step("rej9",  4'd9,  1'b0);
        step("acc0",  4'd0,  1'b0);
        chk("acc0_piece", 32'(bus.PIECE), 32'd0);

        // Single entry with pop+push: new code becomes head, VALID stays 1.
        step("single_pp", 4'd4, 1'b1);
        chk("single_pp_valid", 32'(bus.VALID), 32'd1);

        // Drain, then a TAKE on empty has no effect.
        step("drain",      4'd12, 1'b1);
        chk("drain_piece", 32'(bus.PIECE), 32'd7);
        step("take_empty", 4'd8,  1'b1);

        // Randomised traffic, TAKE biased low so the FIFO spends time full.
        for (int i = 0; i < 120; i++) begin
            logic [3:0] r;
            logic       t;
            r = 4'($urandom_range(0, 15));
            t = ($urandom_range(0, 2) == 0);
            step("rnd", r, t);
        end

        // Repeat filtering from a fresh reset.
        RESET = 1'b1;
        #1;
        sync_reset_model();
        check_all("reset2");
        @(negedge CLK);
        RESET = 1'b0;
        step("rep0", 4'd4, 1'b0);
        step("rep1", 4'd4, 1'b0);
        step("rep2", 4'd4, 1'b0);
        step("rep3", 4'd2, 1'b0);
        chk("rep_piece", 32'(bus.PIECE), 32'd4);
`ifdef PIECE_QUEUE_NO_REPEAT_EN
        chk("rep_preview", 32'(bus.PREVIEW), 32'({3'd7, 3'd7, 3'd2}));
`else
        chk("rep_preview", 32'(bus.PREVIEW), 32'({3'd2, 3'd4, 3'd4}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/piece_queue.md
# piece_queue

Next-piece buffer for Tetris; sits directly downstream of the 4-bit pseudo-random generator. Each cycle it filters the raw 4-bit value into a tetrimino code 0–6 and keeps a FIFO of upcoming pieces. The head of the FIFO is the piece the game FSM spawns next, and the remaining entries drive the "next" preview display. The game FSM consumes the head with a single-cycle `TAKE` strobe.

## Interface
- `DEPTH`, default 4 — total FIFO entries: head plus `DEPTH-1` preview slots; legal range 2–8.
- `CLK` input 1 — system clock; all state updates on the rising edge.
- `RESET` input 1 — asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `RAND` input 4 — raw random value from the generator, sampled every rising edge.
- `TAKE` input 1 — pop request from the game FSM; one cycle per piece.
- `PIECE` output 3 — head entry, i.e. the next piece to spawn; 7 when the FIFO is empty.
- `VALID` output 1 — high when the FIFO holds at least 1 entry.
- `FULL` output 1 — high when the FIFO holds `DEPTH` entries.
- `PREVIEW` output 3*(DEPTH-1) — FIFO slots 1..DEPTH-1; slot 1 at [2:0], slot k at [3k-1:3k-3]; an unoccupied slot reads 7.

## Operation
- Storage: `DEPTH` slots of 3 bits, an occupancy count (0..DEPTH), and a `LAST` register of 3 bits holding the most recently pushed code.
- Candidate: `RAND` is acceptable iff `RAND <= 6`. Values 7–15 are discarded, and nothing is stored for them.
- Pop: when `TAKE=1` and `VALID=1`, slots shift toward the head by one and count decrements. `TAKE` while `VALID=0` is ignored, has no side effects and is not remembered.
- Push: when the candidate is acceptable and there is space, `RAND[2:0]` is written at the tail and `LAST` is updated. There is space when count < `DEPTH`, or when a pop happens in the same cycle.
- Simultaneous pop and push: the shift happens first and the new code lands at index count-1, so count is unchanged. This also holds when full, where the new code lands at index `DEPTH-1`.
- Single entry with simultaneous pop and push: the new code becomes the head, and `VALID` stays 1.
- Unoccupied slots are forced to 7 on every update, so `PIECE` and `PREVIEW` never show stale codes.
- State machine, derived from count:
  - `EMPTY` (0): moves to `FILLING` on a push.
  - `FILLING` (1..DEPTH-1): moves to `FULL` when a push occurs without a pop and count = `DEPTH-1`.
  - `FULL`: a pop without a push returns to `FILLING`; a pop with a push stays in `FULL`.
  - `FILLING` returns to `EMPTY` when count = 1 and the head is popped without a push.
- Outputs: `VALID` = (count != 0) and `FULL` = (count == `DEPTH`), both registered from the state.

## Timing
- Reset values: all slots 7, count 0, `LAST` 7, `PIECE` 7, `PREVIEW` all 7s, `VALID` 0, `FULL` 0.
- Reset asserted mid-operation clears everything immediately and asynchronously. The first push can occur at the first rising edge after `RESET` deasserts.
- Latency: an acceptable `RAND` at edge n is visible at the tail after edge n. Into an empty FIFO, it is on `PIECE` with `VALID=1` after that same edge.
- Fill time: with an acceptable, non-rejected `RAND` every cycle, `FULL` rises after exactly `DEPTH` edges following reset release.
- Pop latency: `PIECE` shows the former slot-1 value after the edge that samples `TAKE`. The game FSM samples `PIECE` in the same cycle it drives `TAKE`.
- No combinational path from inputs to outputs.

## Configuration
- `PIECE_QUEUE_NO_REPEAT_EN` defined: a candidate equal to `LAST` is additionally rejected, so no two consecutive pushed pieces are identical. `LAST` is not cleared by draining the FIFO; only `RESET` clears it to 7.
- Undefined: no repeat filtering; `LAST` is still maintained but unused.

## Test plan
- Reset and fill, `DEPTH`=4: assert `RESET`, check all outputs at reset values. Release and drive `RAND` 3,5,1,6:
  - after 4 edges, `PIECE`=3, `PREVIEW`={6,1,5}, `FULL`=1, `VALID`=1.
- Rejection: drive `RAND` 7, 15, 9 into an empty FIFO -> `VALID` stays 0 and `PIECE`=7. Then `RAND`=0 -> `PIECE`=0, `VALID`=1.
- Pop with push while full: queue {3,5,1,6}, `TAKE`=1, `RAND`=2 -> queue {5,1,6,2}, `FULL` stays 1.
- Drain: queue {4}, `TAKE`=1, `RAND`=12 -> `VALID`=0, `PIECE`=7. Then `TAKE`=1 with `RAND`=8 -> no change.
- Overfill: full queue, `TAKE`=0, `RAND`=2 -> contents unchanged. Async `RESET` pulse mid-cycle -> outputs return to reset values before the next edge.
- With `PIECE_QUEUE_NO_REPEAT_EN`: `RAND` 4,4,4,2 from empty -> queue {4,2}. Without the macro -> queue {4,4,4,2}.
